bus_fabric: RTL and testbench



---
 rtl/bus_fabric_pkg.sv | 28 ++
 rtl/bus_fabric_decode.sv | 36 +++
 rtl/bus_fabric.sv | 189 ++++++++++++++++++
 tb/tb_bus_fabric.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types for the bus fabric: FSM states, fault cause codes and
// the watchdog counter sizing.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_DECERR  = 3'd1,
        CAUSE_SLVERR  = 3'd2,
        CAUSE_TIMEOUT = 3'd3,
        CAUSE_PROTO   = 3'd4
    } cause_e;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned MAX_SLV = 16;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so no
    // zero-width vector is ever declared.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_fabric_decode.sv
// Address decoder: base/mask compare against every slave, then a
// lowest-index-wins priority encoder.
module bus_fabric_decode
    import bus_fabric_pkg::*;
#(
    parameter int unsigned          N_SLV    = 9,
    parameter int unsigned          XLEN     = 32,
    parameter logic [N_SLV*XLEN-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*XLEN-1:0] SLV_MASK = '0
) (
    input  logic [XLEN-1:0]  addr_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_SLV-1:0] match;

    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            match[i] = (addr_i & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN];
        end
    end

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master, N-slave interconnect: one outstanding transaction,
// response watchdog, protocol checks and a sticky fault record.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int unsigned           N_SLV     = 9,
    parameter int unsigned           XLEN      = 32,
    parameter int unsigned           BUS_WIDTH = 32,
    parameter int unsigned           ACC_W     = 2,
    parameter logic [N_SLV*XLEN-1:0] SLV_BASE  = '0,
    parameter logic [N_SLV*XLEN-1:0] SLV_MASK  = '0,
    parameter int unsigned           TIMEOUT   = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [XLEN-1:0]            m_addr,
    input  logic                       m_w_rb,
    input  logic [ACC_W-1:0]           m_acc,
    input  logic [BUS_WIDTH-1:0]       m_wdata,
    input  logic                       m_req,
    output logic [BUS_WIDTH-1:0]       m_rdata,
    output logic                       m_resp,
    output logic                       m_fault,
    output logic [XLEN-1:0]            s_addr,
    output logic                       s_w_rb,
    output logic [ACC_W-1:0]           s_acc,
    output logic [BUS_WIDTH-1:0]       s_wdata,
    output logic [N_SLV-1:0]           s_req,
    input  logic [N_SLV*BUS_WIDTH-1:0] s_rdata,
    input  logic [N_SLV-1:0]           s_resp,
    input  logic [N_SLV-1:0]           s_fault,
    output logic [2:0]                 fault_cause,
    output logic [XLEN-1:0]            fault_addr,
    output logic [IDX_W-1:0]           fault_slv,
    input  logic                       fault_clr
);

    localparam int unsigned WD_W = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [XLEN-1:0]   txn_addr_q, txn_addr_d;
    logic [XLEN-1:0]   faddr_q, faddr_d;
    logic [IDX_W-1:0]  fslv_q, fslv_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [MAX_SLV-1:0]   resp_pad;
    logic [BUS_WIDTH-1:0] rdata_arr [MAX_SLV];
    logic              resp_sel;
    logic              wd_expire;
    logic              slv_fault_any;
    logic [IDX_W-1:0]  slv_fault_idx;
    logic              accept;

    bus_fabric_decode #(
        .N_SLV    (N_SLV),
        .XLEN     (XLEN),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .addr_i (m_addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx)
    );

    assign s_addr  = m_addr;
    assign s_w_rb  = m_w_rb;
    assign s_acc   = m_acc;
    assign s_wdata = m_wdata;

    // Pad to 16 entries so the 4-bit sel indexes both muxes without range issues.
    always_comb begin
        resp_pad = '0;
        resp_pad[N_SLV-1:0] = s_resp;
        for (int i = 0; i < MAX_SLV; i++) rdata_arr[i] = '0;
        for (int i = 0; i < N_SLV; i++) rdata_arr[i] = s_rdata[i*BUS_WIDTH +: BUS_WIDTH];
        slv_fault_any = 1'b0;
        slv_fault_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (s_fault[i]) begin
                slv_fault_any = 1'b1;
                slv_fault_idx = IDX_W'(i);
            end
        end
    end

    assign resp_sel  = resp_pad[sel_q];
    assign m_rdata   = rdata_arr[sel_q];
    assign wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST) && !resp_sel;
    assign m_fault   = (state_q == ST_FAULT);

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        sel_d      = sel_q;
        wd_d       = wd_q;
        txn_addr_d = txn_addr_q;
        faddr_d    = faddr_q;
        fslv_d     = fslv_q;
        s_req      = '0;
        m_resp     = 1'b0;
        accept     = 1'b0;

        unique case (state_q)
            ST_IDLE: accept = m_req;
            ST_BUSY: begin
                if (slv_fault_any) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_SLVERR;
                    faddr_d = txn_addr_q;
                    fslv_d  = slv_fault_idx;
                end else if (m_req && !resp_sel) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_PROTO;
                    faddr_d = txn_addr_q;
                    fslv_d  = sel_q;
                end else if (wd_expire) begin
                    state_d = ST_FAULT;
                    cause_d = CAUSE_TIMEOUT;
                    faddr_d = txn_addr_q;
                    fslv_d  = sel_q;
                end else if (resp_sel) begin
                    m_resp  = 1'b1;
                    state_d = ST_IDLE;
                    accept  = m_req;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_NONE;
                    faddr_d = '0;
                    fslv_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (dec_hit) begin
                for (int i = 0; i < N_SLV; i++) s_req[i] = (dec_idx == IDX_W'(i));
                sel_d      = dec_idx;
                wd_d       = '0;
                txn_addr_d = m_addr;
                state_d    = ST_BUSY;
            end else begin
                state_d = ST_FAULT;
                cause_d = CAUSE_DECERR;
                faddr_d = m_addr;
                fslv_d  = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cause_q    <= CAUSE_NONE;
            sel_q      <= '0;
            wd_q       <= '0;
            txn_addr_q <= '0;
            faddr_q    <= '0;
            fslv_q     <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            sel_q      <= sel_d;
            wd_q       <= wd_d;
            txn_addr_q <= txn_addr_d;
            faddr_q    <= faddr_d;
            fslv_q     <= fslv_d;
        end
    end

    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;
    assign fault_slv   = fslv_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: 3 slaves, TIMEOUT=4; slaves 1 and 2
// overlap on 0x2xxx_xxxx so lowest-index priority is exercised.
module tb_bus_fabric;

    localparam int unsigned N_SLV = 3;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BW    = 32;
    localparam int unsigned ACC_W = 2;
    localparam logic [N_SLV*XLEN-1:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000};
    localparam logic [N_SLV*XLEN-1:0] MASK = {32'hE000_0000, 32'hF000_0000, 32'hF000_0000};

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [XLEN-1:0]       m_addr = '0;
    logic                  m_w_rb = 1'b0;
    logic [ACC_W-1:0]      m_acc = '0;
    logic [BW-1:0]         m_wdata = '0;
    logic                  m_req = 1'b0;
    logic [BW-1:0]         m_rdata;
    logic                  m_resp;
    logic                  m_fault;
    logic [XLEN-1:0]       s_addr;
    logic                  s_w_rb;
    logic [ACC_W-1:0]      s_acc;
    logic [BW-1:0]         s_wdata;
    logic [N_SLV-1:0]      s_req;
    logic [N_SLV*BW-1:0]   s_rdata = '0;
    logic [N_SLV-1:0]      s_resp = '0;
    logic [N_SLV-1:0]      s_fault = '0;
    logic [2:0]            fault_cause;
    logic [XLEN-1:0]       fault_addr;
    logic [3:0]            fault_slv;
    logic                  fault_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bus_fabric #(
        .N_SLV(N_SLV), .XLEN(XLEN), .BUS_WIDTH(BW), .ACC_W(ACC_W),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc), .m_wdata(m_wdata), .m_req(m_req),
        .m_rdata(m_rdata), .m_resp(m_resp), .m_fault(m_fault),
        .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata), .s_req(s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault),
        .fault_cause(fault_cause), .fault_addr(fault_addr), .fault_slv(fault_slv),
        .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Advance to 1 ns after the next rising edge and return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        m_req = 1'b0; s_resp = '0; s_fault = '0; fault_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (m_resp !== 1'b0) begin miscompares++; $display("FAIL rst_m_resp got %b want 0", m_resp); end
        vectors++; if (m_fault !== 1'b0) begin miscompares++; $display("FAIL rst_m_fault got %b want 0", m_fault); end
        vectors++; if (s_req !== 3'b000) begin miscompares++; $display("FAIL rst_s_req got %b want 000", s_req); end
        vectors++; if (fault_cause !== 3'd0) begin miscompares++; $display("FAIL rst_cause got %0d want 0", fault_cause); end
        vectors++; if (fault_addr !== 32'h0) begin miscompares++; $display("FAIL rst_faddr got %h want 0", fault_addr); end
        vectors++; if (fault_slv !== 4'd0) begin miscompares++; $display("FAIL rst_fslv got %0d want 0", fault_slv); end
        #20 rstn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        m_req = 1'b1; m_addr = 32'h2000_0010; m_w_rb = 1'b0; m_acc = 2'd2;
        #1;
        vectors++; if (s_req !== 3'b010) begin miscompares++; $display("FAIL b2b_req1 got %b want 010", s_req); end
        vectors++; if (s_addr !== 32'h2000_0010) begin miscompares++; $display("FAIL b2b_saddr got %h want 20000010", s_addr); end
        step();
        #1;
        vectors++; if (m_resp !== 1'b0 || s_req !== 3'b000) begin miscompares++; $display("FAIL b2b_wait got resp=%b req=%b want 0/000", m_resp, s_req); end
        step();
        s_resp = 3'b010; s_rdata[1*BW +: BW] = 32'hDEAD_BEEF;
        m_req = 1'b1; m_addr = 32'h3000_0004; m_w_rb = 1'b1; m_wdata = 32'hA5A5_0001;
        #1;
        vectors++; if (m_resp !== 1'b1) begin miscompares++; $display("FAIL b2b_resp1 got %b want 1", m_resp); end
        vectors++; if (m_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL b2b_rdata1 got %h want deadbeef", m_rdata); end
        vectors++; if (s_req !== 3'b100) begin miscompares++; $display("FAIL b2b_req2 got %b want 100", s_req); end
        vectors++; if (s_wdata !== 32'hA5A5_0001 || s_w_rb !== 1'b1) begin miscompares++; $display("FAIL b2b_wfields got %h/%b want a5a50001/1", s_wdata, s_w_rb); end
        step();
        s_resp = 3'b001;
        #1;
        vectors++; if (m_resp !== 1'b0) begin miscompares++; $display("FAIL b2b_other_slave got %b want 0", m_resp); end
        step();
        s_resp = 3'b100; s_rdata[2*BW +: BW] = 32'h1234_5678;
        #1;
        vectors++; if (m_resp !== 1'b1 || m_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL b2b_resp2 got %b/%h want 1/12345678", m_resp, m_rdata); end
        step();
        vectors++; if (m_fault !== 1'b0) begin miscompares++; $display("FAIL b2b_nofault got %b want 0", m_fault); end
    endtask

    task automatic test_decode_error();
        m_req = 1'b1; m_addr = 32'h9000_0000; m_w_rb = 1'b0;
        #1;
        vectors++; if (s_req !== 3'b000) begin miscompares++; $display("FAIL dec_sreq got %b want 000", s_req); end
        step();
        vectors++; if (m_fault !== 1'b1 || fault_cause !== 3'd1) begin miscompares++; $display("FAIL dec_fault got %b/%0d want 1/1", m_fault, fault_cause); end
        vectors++; if (fault_addr !== 32'h9000_0000 || fault_slv !== 4'd0) begin miscompares++; $display("FAIL dec_record got %h/%0d want 90000000/0", fault_addr, fault_slv); end
        m_req = 1'b1; m_addr = 32'h1000_0000;
        #1;
        vectors++; if (s_req !== 3'b000) begin miscompares++; $display("FAIL dec_req_in_fault got %b want 000", s_req); end
        step();
        fault_clr = 1'b1;
        #1;
        vectors++; if (m_fault !== 1'b1) begin miscompares++; $display("FAIL dec_clr_cycle got %b want 1", m_fault); end
        step();
        vectors++; if (m_fault !== 1'b0 || fault_cause !== 3'd0 || fault_addr !== 32'h0) begin miscompares++; $display("FAIL dec_cleared got %b/%0d/%h want 0/0/0", m_fault, fault_cause, fault_addr); end
        m_req = 1'b1; m_addr = 32'h1000_0040;
        #1;
        vectors++; if (s_req !== 3'b001) begin miscompares++; $display("FAIL dec_next_req got %b want 001", s_req); end
        step();
        s_resp = 3'b001; s_rdata[0 +: BW] = 32'h0BAD_F00D;
        #1;
        vectors++; if (m_resp !== 1'b1 || m_rdata !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL dec_next_resp got %b/%h want 1/0badf00d", m_resp, m_rdata); end
        step();
    endtask

    task automatic test_timeout();
        // Response raised in the request cycle must be ignored.
        m_req = 1'b1; m_addr = 32'h3000_0000; s_resp = 3'b100;
        #1;
        vectors++; if (m_resp !== 1'b0 || s_req !== 3'b100) begin miscompares++; $display("FAIL to_req got %b/%b want 0/100", m_resp, s_req); end
        for (int k = 1; k <= 4; k++) begin
            step();
            vectors++; if (m_fault !== 1'b0) begin miscompares++; $display("FAIL to_early_c%0d got %b want 0", k, m_fault); end
        end
        step();
        vectors++; if (m_fault !== 1'b1 || fault_cause !== 3'd3) begin miscompares++; $display("FAIL to_fault_c5 got %b/%0d want 1/3", m_fault, fault_cause); end
        vectors++; if (fault_slv !== 4'd2 || fault_addr !== 32'h3000_0000) begin miscompares++; $display("FAIL to_record got %0d/%h want 2/30000000", fault_slv, fault_addr); end
        fault_clr = 1'b1;
        step();
        m_req = 1'b1; m_addr = 32'h3000_0000;
        for (int k = 1; k <= 3; k++) step();
        s_resp = 3'b100;
        #1;
        vectors++; if (m_resp !== 1'b1) begin miscompares++; $display("FAIL to_late_resp got %b want 1", m_resp); end
        step();
        vectors++; if (m_fault !== 1'b0) begin miscompares++; $display("FAIL to_no_fault got %b want 0", m_fault); end
    endtask

    task automatic test_slverr();
        m_req = 1'b1; m_addr = 32'h2000_0000;
        step();
        s_resp = 3'b010; s_fault = 3'b010;
        #1;
        vectors++; if (m_resp !== 1'b0) begin miscompares++; $display("FAIL slv_resp_forced got %b want 0", m_resp); end
        step();
        vectors++; if (m_fault !== 1'b1 || fault_cause !== 3'd2 || fault_slv !== 4'd1) begin miscompares++; $display("FAIL slv_record got %b/%0d/%0d want 1/2/1", m_fault, fault_cause, fault_slv); end
        fault_clr = 1'b1;
        step();
    endtask

    task automatic test_proto_and_reset();
        m_req = 1'b1; m_addr = 32'h1000_0000;
        step();
        m_req = 1'b1; m_addr = 32'h2000_0000;
        #1;
        vectors++; if (s_req !== 3'b000 || m_resp !== 1'b0) begin miscompares++; $display("FAIL proto_no_req got %b/%b want 000/0", s_req, m_resp); end
        step();
        vectors++; if (m_fault !== 1'b1 || fault_cause !== 3'd4) begin miscompares++; $display("FAIL proto_record got %b/%0d want 1/4", m_fault, fault_cause); end
        #2 rstn = 1'b0;
        #1;
        vectors++; if (m_fault !== 1'b0 || fault_cause !== 3'd0) begin miscompares++; $display("FAIL rst_from_fault got %b/%0d want 0/0", m_fault, fault_cause); end
        rstn = 1'b1;
        step();
        m_req = 1'b1; m_addr = 32'h1000_0000;
        step();
        rstn = 1'b0; s_resp = 3'b001;
        #1;
        vectors++; if (s_req !== 3'b000 || m_resp !== 1'b0 || m_fault !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b/%b/%b want 000/0/0", s_req, m_resp, m_fault); end
        s_resp = '0;
        #2 rstn = 1'b1;
        step();
        #1;
        vectors++; if (s_req !== 3'b000 || m_resp !== 1'b0) begin miscompares++; $display("FAIL rst_no_reissue got %b/%b want 000/0", s_req, m_resp); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_decode_error();
        test_timeout();
        test_slverr();
        test_proto_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
